x_stream_serializer: RTL and testbench

//  Parallel-to-serial front end for the x-input sequence-detector FSMs.

---
 rtl/x_stream_serializer.sv | 148 ++++++++++++++
 tb/tb_x_stream_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_stream_serializer.sv
// x_stream_serializer: accepts WIDTH-bit words over valid/ready and shifts them out MSB-first on x_out.
// Define PARITY_BIT_EN to append an even-parity bit to every frame.
module x_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             frame_active,
  output logic             frame_start,
  output logic             done,
  output logic [15:0]      frames_sent
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] TOP_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
`ifdef PARITY_BIT_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef PARITY_BIT_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t             state_q, state_n;
  logic               buf_full, ready_en, accept, take, frame_end;
  logic [WIDTH-1:0]   buf_data, shreg, shreg_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [3:0]         gap_cnt, gap_cnt_n;
  logic               x_n, active_n, start_n, done_n;

  // ready_en keeps load_ready low until the first edge after reset
  assign load_ready = ready_en & ~buf_full;
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    x_n       = IDLE_LEVEL;
    active_n  = 1'b0;
    start_n   = 1'b0;
    done_n    = 1'b0;
    take      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: take = buf_full;
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
          x_n       = shreg[bit_cnt_n];
          active_n  = 1'b1;
          done_n    = (bit_cnt_n == '0) && !PAR_EN;
        end else begin
`ifdef PARITY_BIT_EN
          state_n  = S_PAR;
          x_n      = ^shreg;
          active_n = 1'b1;
          done_n   = 1'b1;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PARITY_BIT_EN
      S_PAR: frame_end = 1'b1;
`endif
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_n = S_IDLE;
          take    = buf_full;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (frame_end) begin
      if (GAP > 0) begin
        state_n   = S_GAP;
        gap_cnt_n = GAP_LOAD;
      end else begin
        state_n = S_IDLE;
        take    = buf_full;
      end
    end

    // A buffered word starts immediately, overriding any idle/exit choice above
    if (take) begin
      state_n   = S_SHIFT;
      shreg_n   = buf_data;
      bit_cnt_n = TOP_BIT;
      x_n       = buf_data[WIDTH-1];
      active_n  = 1'b1;
      start_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= 4'd0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      ready_en     <= 1'b0;
      x_out        <= IDLE_LEVEL;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      done         <= 1'b0;
      frames_sent  <= 16'd0;
    end else begin
      state_q      <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      ready_en     <= 1'b1;
      x_out        <= x_n;
      frame_active <= active_n;
      frame_start  <= start_n;
      done         <= done_n;
      if (done) frames_sent <= frames_sent + 16'd1;
      if (take) begin
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_data <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_x_stream_serializer.sv
// tb_x_stream_serializer: two serializers (GAP=0/idle 0 and GAP=3/idle 1) checked against a queue-based line model.
// Honors PARITY_BIT_EN the same way the design does.
module tb_x_stream_serializer;

  localparam int W = 8;
`ifdef PARITY_BIT_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic x;
    logic act;
    logic st;
    logic dn;
  } rec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in [2];
  logic         load_valid [2];
  logic         load_ready [2];
  logic         x_out [2];
  logic         frame_active [2];
  logic         frame_start [2];
  logic         done [2];
  logic [15:0]  frames_sent [2];

  int checks = 0;
  int errors = 0;
  int total_words = 0;

  rec_t         line_q [2][$];
  logic [W-1:0] src_q [2][$];
  rec_t         cur [2];
  bit           m_buf_full [2];
  logic [W-1:0] m_buf [2];
  bit           m_started [2];
  logic [15:0]  m_cnt [2];

  always #5 clk = ~clk;

  x_stream_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in[0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .x_out(x_out[0]), .frame_active(frame_active[0]),
    .frame_start(frame_start[0]), .done(done[0]), .frames_sent(frames_sent[0])
  );

  x_stream_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b1), .GAP(3)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .x_out(x_out[1]), .frame_active(frame_active[1]),
    .frame_start(frame_start[1]), .done(done[1]), .frames_sent(frames_sent[1])
  );

  function automatic logic idle_of(int i);
    return (i == 1);
  endfunction

  function automatic int gap_of(int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic rec_t idle_rec(int i);
    rec_t r;
    r.x = idle_of(i); r.act = 1'b0; r.st = 1'b0; r.dn = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      line_q[i].delete();
      src_q[i].delete();
      m_buf_full[i] = 1'b0;
      m_buf[i]      = '0;
      m_started[i]  = 1'b0;
      m_cnt[i]      = 16'd0;
      cur[i]        = idle_rec(i);
    end
  endtask

  // A frame is the data bits MSB-first, optional parity, then the idle gap slots
  task automatic push_frame(int i, logic [W-1:0] w);
    rec_t r;
    for (int b = W - 1; b >= 0; b--) begin
      r.x = w[b]; r.act = 1'b1; r.st = (b == W - 1); r.dn = (b == 0) && !PAR;
      line_q[i].push_back(r);
    end
    if (PAR) begin
      r.x = ^w; r.act = 1'b1; r.st = 1'b0; r.dn = 1'b1;
      line_q[i].push_back(r);
    end
    for (int g = 0; g < gap_of(i); g++) line_q[i].push_back(idle_rec(i));
  endtask

  task automatic model_edge();
    bit acc;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      acc = load_valid[i] && m_started[i] && !m_buf_full[i];
      if (cur[i].dn) m_cnt[i] = m_cnt[i] + 16'd1;
      if (line_q[i].size() == 0 && m_buf_full[i]) begin
        push_frame(i, m_buf[i]);
        m_buf_full[i] = 1'b0;
      end
      cur[i] = (line_q[i].size() > 0) ? line_q[i].pop_front() : idle_rec(i);
      if (acc) begin
        m_buf_full[i] = 1'b1;
        m_buf[i]      = data_in[i];
        void'(src_q[i].pop_front());
      end
      m_started[i] = 1'b1;
    end
  endtask

  task automatic check_val(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("x_out[%0d]", i), 16'(x_out[i]), 16'(cur[i].x));
      check_val($sformatf("frame_active[%0d]", i), 16'(frame_active[i]), 16'(cur[i].act));
      check_val($sformatf("frame_start[%0d]", i), 16'(frame_start[i]), 16'(cur[i].st));
      check_val($sformatf("done[%0d]", i), 16'(done[i]), 16'(cur[i].dn));
      check_val($sformatf("load_ready[%0d]", i), 16'(load_ready[i]),
                16'(m_started[i] && !m_buf_full[i]));
      check_val($sformatf("frames_sent[%0d]", i), frames_sent[i], m_cnt[i]);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      load_valid[i] = (src_q[i].size() > 0);
      data_in[i]    = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic applyStimulus(logic [W-1:0] w);
    for (int i = 0; i < 2; i++) src_q[i].push_back(w);
    drive_inputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput();
    drive_inputs();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    drive_inputs();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single word A5
    applyStimulus(8'hA5);
    repeat (20) tick();
    check_val("t1_frames0", frames_sent[0], 16'd1);
    check_val("t1_frames1", frames_sent[1], 16'd1);

    // Back-to-back FF, 00
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    repeat (40) tick();
    check_val("t2_frames0", frames_sent[0], 16'd3);
    check_val("t2_frames1", frames_sent[1], 16'd3);

    // Reset mid-frame with a second word buffered
    applyStimulus(8'hC3);
    applyStimulus(8'h5A);
    repeat (4) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_val("rst_x_out0", 16'(x_out[0]), 16'd0);
    check_val("rst_x_out1", 16'(x_out[1]), 16'd1);
    check_val("rst_frames0", frames_sent[0], 16'd0);
    checkOutput();
    drive_inputs();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_val("rst_ready0", 16'(load_ready[0]), 16'd1);
    repeat (20) tick();
    check_val("rst_no_frame0", frames_sent[0], 16'd0);

    // Parity-sensitive pair, then a held word behind a full buffer
    applyStimulus(8'hA5);
    applyStimulus(8'h07);
    repeat (40) tick();
    check_val("t5_frames0", frames_sent[0], 16'd2);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h3C);
    repeat (60) tick();
    check_val("t6_frames0", frames_sent[0], 16'd5);
    check_val("t6_frames1", frames_sent[1], 16'd5);

    // Randomized bursts and pauses
    for (int it = 0; it < 25; it++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) applyStimulus(W'($urandom));
      total_words += n;
      repeat ($urandom_range(0, 30)) tick();
    end
    repeat (1200) tick();
    check_val("final_frames0", frames_sent[0], 16'(5 + total_words));
    check_val("final_frames1", frames_sent[1], 16'(5 + total_words));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
